tcp_client_hs: RTL and testbench
================================

TCP_CLIENT_HS -- requirements
Module: tcp_client_hs

Interface
REQ-001 SHALL have parameter RTX_TICKS, default 1000, cycles before a retransmission.
REQ-002 SHALL have parameter RTX_MAX, default 3, retransmissions before abort.
REQ-003 SHALL have parameter TW_TICKS, default 2000, TIME_WAIT duration in cycles.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port connect  in  1  active-open request pulse.
REQ-007 SHALL have port disconnect  in  1  active-close request pulse.
REQ-008 SHALL have port loc_port  in  16  local port.
REQ-009 SHALL have port rem_port  in  16  remote port.
REQ-010 SHALL have port isn  in  32  initial sequence number, sampled on accepted connect.
REQ-011 SHALL have port rx_vld  in  1  received header valid, one cycle.
REQ-012 SHALL have port rx_flags  in  4  {syn,ack,fin,rst}.
REQ-013 SHALL have port rx_src_port  in  16  received source port.
REQ-014 SHALL have port rx_dst_port  in  16  received destination port.
REQ-015 SHALL have port rx_seq  in  32  received sequence number.
REQ-016 SHALL have port rx_ack_num  in  32  received acknowledgement number.
REQ-017 SHALL have port tx_req  out  1  segment pending.
REQ-018 SHALL have port tx_acc  in  1  segment taken by transmitter.
REQ-019 SHALL have port tx_flags  out  4  {syn,ack,fin,rst}.
REQ-020 SHALL have port tx_seq  out  32  / tx_ack_num  out  32  outgoing header numbers.
REQ-021 SHALL have port state  out  3  CLOSED=0, SYN_SENT=1, ESTABLISHED=2, FIN_WAIT_1=3, FIN_WAIT_2=4, TIME_WAIT=5, LAST_ACK=6.
REQ-022 SHALL have port failed  out  1  one-cycle pulse on abort or received reset.

Function
REQ-023 Matching segment SHALL mean rx_vld, rx_dst_port==loc_port, rx_src_port==rem_port; non-matching input ignored.
REQ-024 Queue: one-entry buffer; tx_req and fields held stable until tx_req&&tx_acc, tx_req low next cycle; a newly queued segment overwrites an unaccepted one.
REQ-025 CLOSED+connect: loc_seq<=isn; queue SYN seq=isn ack_num=0; ->SYN_SENT; connect ignored in other states.
REQ-026 SYN_SENT, match, syn&ack, rx_ack_num==isn+1: loc_seq<=isn+1, rem_seq<=rx_seq+1; queue ACK; ->ESTABLISHED.
REQ-027 SYN_SENT, match, ack, wrong rx_ack_num, no rst: queue RST seq=rx_ack_num; stay SYN_SENT.
REQ-028 ESTABLISHED+disconnect: queue FIN|ACK seq=loc_seq ack_num=rem_seq; ->FIN_WAIT_1; disconnect ignored elsewhere.
REQ-029 ESTABLISHED, matching fin: rem_seq<=rx_seq+1; queue FIN|ACK; ->LAST_ACK; wins over simultaneous disconnect.
REQ-030 FIN_WAIT_1, ack with rx_ack_num==loc_seq+1: loc_seq+1; with fin also: rem_seq<=rx_seq+1, queue ACK, ->TIME_WAIT; else ->FIN_WAIT_2.
REQ-031 FIN_WAIT_2, fin: rem_seq<=rx_seq+1; queue ACK; ->TIME_WAIT.
REQ-032 TIME_WAIT: ->CLOSED after TW_TICKS cycles; repeated fin re-queues ACK and restarts count.
REQ-033 LAST_ACK, ack with rx_ack_num==loc_seq+1: ->CLOSED.
REQ-034 Timer in SYN_SENT/FIN_WAIT_1/LAST_ACK clears on state entry, expires after RTX_TICKS cycles: re-queue last segment, retry+1; expiry at retry==RTX_MAX: queue RST, pulse failed, ->CLOSED.
REQ-035 Matching rst in any non-CLOSED state: drop pending segment, pulse failed, ->CLOSED, takes priority over all other events.
REQ-036 Sequence arithmetic SHALL wrap modulo 2^32.

Reset
REQ-037 rst low at an edge SHALL force state=CLOSED, tx_req=0, all outputs, counters, sequence registers 0, dropping any pending segment without handshake.

Verification
REQ-038 connect, isn=0x100; SYN-ACK rx_seq=0x500 ack=0x101 -> SYN seq 0x100, then ACK seq 0x101 ack 0x501, state 2.
REQ-039 isn=0xFFFFFFFF, SYN-ACK rx_ack_num=0 -> ACK seq 0, state 2.
REQ-040 SYN_SENT, no reply, RTX_TICKS=4 RTX_MAX=3 -> 3 SYN re-sends, then RST, failed, state 0.
REQ-041 ESTABLISHED, disconnect, ack+fin -> FIN|ACK, ACK, TIME_WAIT, CLOSED after TW_TICKS.
REQ-042 SYN_SENT, ack with wrong rx_ack_num=0x777 -> RST seq 0x777, state stays 1; rst while tx_req pending -> tx_req drops, failed, state 0.

Source files
------------

// File: rtl/tcp_client_hs_if.sv
// Handshake bundle between the TCP client handshake engine and its environment:
// control pulses, received header fields and the one-entry transmit queue.
interface tcp_client_hs_if;
  logic        connect;
  logic        disconnect;
  logic [15:0] loc_port;
  logic [15:0] rem_port;
  logic [31:0] isn;
  logic        rx_vld;
  logic [3:0]  rx_flags;
  logic [15:0] rx_src_port;
  logic [15:0] rx_dst_port;
  logic [31:0] rx_seq;
  logic [31:0] rx_ack_num;
  logic        tx_req;
  logic        tx_acc;
  logic [3:0]  tx_flags;
  logic [31:0] tx_seq;
  logic [31:0] tx_ack_num;
  logic [2:0]  state;
  logic        failed;

  modport master (
    input  connect, disconnect, loc_port, rem_port, isn,
    input  rx_vld, rx_flags, rx_src_port, rx_dst_port, rx_seq, rx_ack_num,
    input  tx_acc,
    output tx_req, tx_flags, tx_seq, tx_ack_num, state, failed
  );

  modport slave (
    output connect, disconnect, loc_port, rem_port, isn,
    output rx_vld, rx_flags, rx_src_port, rx_dst_port, rx_seq, rx_ack_num,
    output tx_acc,
    input  tx_req, tx_flags, tx_seq, tx_ack_num, state, failed
  );
endinterface

// File: rtl/tcp_client_hs.sv
// Client-side TCP connection state machine: active open, active and passive close,
// retransmission timer with abort, TIME_WAIT, and a one-entry outgoing segment queue.
module tcp_client_hs #(
  parameter int RTX_TICKS = 1000,
  parameter int RTX_MAX   = 3,
  parameter int TW_TICKS  = 2000
) (
  input  logic           clk,
  input  logic           rst,
  tcp_client_hs_if.master bus
);

  typedef enum logic [2:0] {
    CLOSED      = 3'd0,
    SYN_SENT    = 3'd1,
    ESTABLISHED = 3'd2,
    FIN_WAIT_1  = 3'd3,
    FIN_WAIT_2  = 3'd4,
    TIME_WAIT   = 3'd5,
    LAST_ACK    = 3'd6
  } state_t;

  localparam logic [3:0]  F_SYN    = 4'b1000;
  localparam logic [3:0]  F_ACK    = 4'b0100;
  localparam logic [3:0]  F_FIN    = 4'b0010;
  localparam logic [3:0]  F_RST    = 4'b0001;
  localparam logic [31:0] RTX_LAST = 32'(RTX_TICKS - 1);
  localparam logic [31:0] TW_LAST  = 32'(TW_TICKS - 1);
  localparam logic [31:0] RTX_LIM  = 32'(RTX_MAX);

  state_t      st;
  logic [31:0] loc_seq;
  logic [31:0] rem_seq;
  logic [31:0] timer;
  logic [31:0] retry;
  logic        tx_req_r;
  logic [3:0]  tx_flags_r;
  logic [31:0] tx_seq_r;
  logic [31:0] tx_ack_r;
  logic [3:0]  last_flags;
  logic [31:0] last_seq;
  logic [31:0] last_ack;
  logic        failed_r;

  logic        match;
  logic        f_syn, f_ack, f_fin, f_rst;
  logic        ack_ok;
  logic        timed;
  logic        timed_event;
  logic [31:0] rx_seq_p1;

  assign match     = bus.rx_vld && (bus.rx_dst_port == bus.loc_port) &&
                     (bus.rx_src_port == bus.rem_port);
  assign f_syn     = bus.rx_flags[3];
  assign f_ack     = bus.rx_flags[2];
  assign f_fin     = bus.rx_flags[1];
  assign f_rst     = bus.rx_flags[0];
  assign rx_seq_p1 = bus.rx_seq + 32'd1;
  assign ack_ok    = match && f_ack && (bus.rx_ack_num == loc_seq + 32'd1);
  assign timed     = (st == SYN_SENT) || (st == FIN_WAIT_1) || (st == LAST_ACK);
  // Any ack in SYN_SENT is answered (good or bad); elsewhere only the expected ack counts.
  assign timed_event = (st == SYN_SENT) ? (match && f_ack) : ack_ok;

  assign bus.tx_req     = tx_req_r;
  assign bus.tx_flags   = tx_flags_r;
  assign bus.tx_seq     = tx_seq_r;
  assign bus.tx_ack_num = tx_ack_r;
  assign bus.state      = st;
  assign bus.failed     = failed_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= CLOSED;
      loc_seq    <= '0;
      rem_seq    <= '0;
      timer      <= '0;
      retry      <= '0;
      tx_req_r   <= 1'b0;
      tx_flags_r <= '0;
      tx_seq_r   <= '0;
      tx_ack_r   <= '0;
      last_flags <= '0;
      last_seq   <= '0;
      last_ack   <= '0;
      failed_r   <= 1'b0;
    end else begin
      failed_r <= 1'b0;
      // Accepted segment leaves the queue; a segment queued below overrides this.
      if (tx_req_r && bus.tx_acc)
        tx_req_r <= 1'b0;

      if (st != CLOSED && match && f_rst) begin
        tx_req_r <= 1'b0;
        failed_r <= 1'b1;
        st       <= CLOSED;
        timer    <= '0;
        retry    <= '0;
      end else if (timed && !timed_event) begin
        if (timer == RTX_LAST) begin
          timer <= '0;
          if (retry == RTX_LIM) begin
            tx_req_r   <= 1'b1;
            tx_flags_r <= F_RST;
            tx_seq_r   <= loc_seq;
            tx_ack_r   <= '0;
            failed_r   <= 1'b1;
            st         <= CLOSED;
            retry      <= '0;
          end else begin
            tx_req_r   <= 1'b1;
            tx_flags_r <= last_flags;
            tx_seq_r   <= last_seq;
            tx_ack_r   <= last_ack;
            retry      <= retry + 32'd1;
          end
        end else begin
          timer <= timer + 32'd1;
        end
      end else begin
        case (st)
          CLOSED: begin
            if (bus.connect) begin
              loc_seq    <= bus.isn;
              rem_seq    <= '0;
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_SYN;
              tx_seq_r   <= bus.isn;
              tx_ack_r   <= '0;
              last_flags <= F_SYN;
              last_seq   <= bus.isn;
              last_ack   <= '0;
              timer      <= '0;
              retry      <= '0;
              st         <= SYN_SENT;
            end
          end
          SYN_SENT: begin
            if (ack_ok && f_syn) begin
              loc_seq    <= loc_seq + 32'd1;
              rem_seq    <= rx_seq_p1;
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_ACK;
              tx_seq_r   <= loc_seq + 32'd1;
              tx_ack_r   <= rx_seq_p1;
              st         <= ESTABLISHED;
            end else begin
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_RST;
              tx_seq_r   <= bus.rx_ack_num;
              tx_ack_r   <= '0;
            end
          end
          ESTABLISHED: begin
            if (match && f_fin) begin
              rem_seq    <= rx_seq_p1;
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_FIN | F_ACK;
              tx_seq_r   <= loc_seq;
              tx_ack_r   <= rx_seq_p1;
              last_flags <= F_FIN | F_ACK;
              last_seq   <= loc_seq;
              last_ack   <= rx_seq_p1;
              timer      <= '0;
              retry      <= '0;
              st         <= LAST_ACK;
            end else if (bus.disconnect) begin
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_FIN | F_ACK;
              tx_seq_r   <= loc_seq;
              tx_ack_r   <= rem_seq;
              last_flags <= F_FIN | F_ACK;
              last_seq   <= loc_seq;
              last_ack   <= rem_seq;
              timer      <= '0;
              retry      <= '0;
              st         <= FIN_WAIT_1;
            end
          end
          FIN_WAIT_1: begin
            loc_seq <= loc_seq + 32'd1;
            if (f_fin) begin
              rem_seq    <= rx_seq_p1;
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_ACK;
              tx_seq_r   <= loc_seq + 32'd1;
              tx_ack_r   <= rx_seq_p1;
              timer      <= '0;
              st         <= TIME_WAIT;
            end else begin
              st <= FIN_WAIT_2;
            end
          end
          FIN_WAIT_2: begin
            if (match && f_fin) begin
              rem_seq    <= rx_seq_p1;
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_ACK;
              tx_seq_r   <= loc_seq;
              tx_ack_r   <= rx_seq_p1;
              timer      <= '0;
              st         <= TIME_WAIT;
            end
          end
          TIME_WAIT: begin
            if (match && f_fin) begin
              tx_req_r   <= 1'b1;
              tx_flags_r <= F_ACK;
              tx_seq_r   <= loc_seq;
              tx_ack_r   <= rem_seq;
              timer      <= '0;
            end else if (timer == TW_LAST) begin
              timer <= '0;
              st    <= CLOSED;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          LAST_ACK: begin
            timer <= '0;
            st    <= CLOSED;
          end
          default: st <= CLOSED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcp_client_hs.sv
// Scoreboard bench for tcp_client_hs: expected segments are queued as stimulus is
// driven and popped as the transmit queue hands segments off.
module tb_tcp_client_hs;
  localparam int RTX_TICKS = 4;
  localparam int RTX_MAX   = 3;
  localparam int TW_TICKS  = 8;
  localparam logic [15:0] LOC = 16'h1234;
  localparam logic [15:0] REM = 16'h0050;
  localparam logic [3:0] F_SYN = 4'b1000, F_ACK = 4'b0100, F_FIN = 4'b0010, F_RST = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tcp_client_hs_if bus();

  tcp_client_hs #(.RTX_TICKS(RTX_TICKS), .RTX_MAX(RTX_MAX), .TW_TICKS(TW_TICKS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [67:0] exp_q[$];
  int checks      = 0;
  int passed      = 0;
  int fail_pulses = 0;
  int f0;

  task automatic checkOutput(input string tag, input logic [67:0] got, input logic [67:0] want);
    checks++;
    if (got !== want)
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    else
      passed++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectSeg(input logic [3:0] f, input logic [31:0] s, input logic [31:0] a);
    exp_q.push_back({f, s, a});
  endtask

  task automatic applyStimulus(input logic [3:0] f, input logic [31:0] s, input logic [31:0] a,
                               input bit good);
    bus.rx_flags    = f;
    bus.rx_seq      = s;
    bus.rx_ack_num  = a;
    bus.rx_src_port = REM;
    bus.rx_dst_port = good ? LOC : 16'hBEEF;
    bus.rx_vld      = 1'b1;
    step(1);
    bus.rx_vld      = 1'b0;
  endtask

  task automatic pulseConnect(input logic [31:0] i);
    bus.isn     = i;
    bus.connect = 1'b1;
    step(1);
    bus.connect = 1'b0;
  endtask

  task automatic pulseDisconnect();
    bus.disconnect = 1'b1;
    step(1);
    bus.disconnect = 1'b0;
  endtask

  // Transmitter side: every handed-off segment must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.failed)
      fail_pulses++;
    if (bus.tx_req && bus.tx_acc) begin
      if (exp_q.size() == 0)
        checkOutput("sb_unexpected_seg", {bus.tx_flags, bus.tx_seq, bus.tx_ack_num}, 68'd0);
      else
        checkOutput("sb_seg", {bus.tx_flags, bus.tx_seq, bus.tx_ack_num}, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.connect     = 1'b0;
    bus.disconnect  = 1'b0;
    bus.loc_port    = LOC;
    bus.rem_port    = REM;
    bus.isn         = '0;
    bus.rx_vld      = 1'b0;
    bus.rx_flags    = '0;
    bus.rx_src_port = '0;
    bus.rx_dst_port = '0;
    bus.rx_seq      = '0;
    bus.rx_ack_num  = '0;
    bus.tx_acc      = 1'b1;

    rst = 1'b0;
    step(3);
    checkOutput("reset_state", bus.state, 0);
    checkOutput("reset_tx_req", bus.tx_req, 0);
    checkOutput("reset_failed", bus.failed, 0);
    rst = 1'b1;
    step(1);

    pulseDisconnect();
    checkOutput("closed_ignores_disconnect", bus.state, 0);

    // Active open with isn 0x100
    expectSeg(F_SYN, 32'h100, 32'h0);
    pulseConnect(32'h100);
    checkOutput("syn_sent_state", bus.state, 1);
    expectSeg(F_ACK, 32'h101, 32'h501);
    applyStimulus(F_SYN | F_ACK, 32'h500, 32'h101, 1'b1);
    checkOutput("established_state", bus.state, 2);
    pulseConnect(32'h999);
    checkOutput("est_ignores_connect", bus.state, 2);
    applyStimulus(F_FIN, 32'h501, 32'h0, 1'b0);
    checkOutput("nonmatch_fin_ignored", bus.state, 2);

    // Active close, ack+fin together, then TIME_WAIT expiry
    expectSeg(F_FIN | F_ACK, 32'h101, 32'h501);
    pulseDisconnect();
    checkOutput("fin_wait_1_state", bus.state, 3);
    expectSeg(F_ACK, 32'h102, 32'h502);
    applyStimulus(F_FIN | F_ACK, 32'h501, 32'h102, 1'b1);
    checkOutput("time_wait_state", bus.state, 5);
    step(TW_TICKS - 1);
    checkOutput("time_wait_held", bus.state, 5);
    step(1);
    checkOutput("time_wait_expired", bus.state, 0);

    // Sequence wrap at 2^32
    expectSeg(F_SYN, 32'hFFFF_FFFF, 32'h0);
    pulseConnect(32'hFFFF_FFFF);
    expectSeg(F_ACK, 32'h0, 32'h11);
    applyStimulus(F_SYN | F_ACK, 32'h10, 32'h0, 1'b1);
    checkOutput("wrap_established", bus.state, 2);

    // Passive close: fin wins over a simultaneous disconnect
    expectSeg(F_FIN | F_ACK, 32'h0, 32'h12);
    bus.disconnect = 1'b1;
    applyStimulus(F_FIN | F_ACK, 32'h11, 32'h0, 1'b1);
    bus.disconnect = 1'b0;
    checkOutput("last_ack_state", bus.state, 6);
    applyStimulus(F_ACK, 32'h12, 32'h1, 1'b1);
    checkOutput("last_ack_closed", bus.state, 0);

    // FIN_WAIT_2 path with a repeated fin restarting TIME_WAIT
    expectSeg(F_SYN, 32'h4000, 32'h0);
    pulseConnect(32'h4000);
    expectSeg(F_ACK, 32'h4001, 32'h9001);
    applyStimulus(F_SYN | F_ACK, 32'h9000, 32'h4001, 1'b1);
    expectSeg(F_FIN | F_ACK, 32'h4001, 32'h9001);
    pulseDisconnect();
    applyStimulus(F_ACK, 32'h9001, 32'h4002, 1'b1);
    checkOutput("fin_wait_2_state", bus.state, 4);
    expectSeg(F_ACK, 32'h4002, 32'h9002);
    applyStimulus(F_FIN | F_ACK, 32'h9001, 32'h4002, 1'b1);
    checkOutput("fw2_time_wait", bus.state, 5);
    step(2);
    expectSeg(F_ACK, 32'h4002, 32'h9002);
    applyStimulus(F_FIN | F_ACK, 32'h9001, 32'h4002, 1'b1);
    step(TW_TICKS - 1);
    checkOutput("tw_restart_held", bus.state, 5);
    step(1);
    checkOutput("tw_restart_expired", bus.state, 0);

    // No reply to SYN: three re-sends, then RST and abort
    f0 = fail_pulses;
    repeat (RTX_MAX + 1) expectSeg(F_SYN, 32'h700, 32'h0);
    expectSeg(F_RST, 32'h700, 32'h0);
    pulseConnect(32'h700);
    step(RTX_TICKS * (RTX_MAX + 1) + 6);
    checkOutput("rtx_abort_state", bus.state, 0);
    checkOutput("rtx_abort_failed", fail_pulses, f0 + 1);
    checkOutput("rtx_all_segments", exp_q.size(), 0);

    // Wrong ack in SYN_SENT, then peer reset while a segment is pending
    expectSeg(F_SYN, 32'h2000, 32'h0);
    pulseConnect(32'h2000);
    expectSeg(F_RST, 32'h777, 32'h0);
    applyStimulus(F_ACK, 32'h5555, 32'h777, 1'b1);
    checkOutput("bad_ack_stays", bus.state, 1);
    step(1);
    bus.tx_acc = 1'b0;
    applyStimulus(F_ACK, 32'h5555, 32'h777, 1'b1);
    checkOutput("pending_tx_req", bus.tx_req, 1);
    checkOutput("pending_tx_flags", bus.tx_flags, F_RST);
    f0 = fail_pulses;
    applyStimulus(F_RST, 32'h5555, 32'h0, 1'b1);
    checkOutput("rst_drops_tx_req", bus.tx_req, 0);
    checkOutput("rst_closed", bus.state, 0);
    bus.tx_acc = 1'b1;
    step(1);
    checkOutput("rst_failed_pulse", fail_pulses, f0 + 1);
    checkOutput("rst_tx_stays_low", bus.tx_req, 0);

    // Local reset with a segment pending
    bus.tx_acc = 1'b0;
    pulseConnect(32'h3000);
    checkOutput("pre_reset_pending", bus.tx_req, 1);
    rst = 1'b0;
    step(1);
    checkOutput("mid_reset_state", bus.state, 0);
    checkOutput("mid_reset_tx_req", bus.tx_req, 0);
    checkOutput("mid_reset_tx_seq", bus.tx_seq, 0);
    rst = 1'b1;
    bus.tx_acc = 1'b1;
    step(2);
    checkOutput("post_reset_idle", {bus.state, bus.tx_req}, 0);

    step(2);
    checkOutput("sb_drained", exp_q.size(), 0);
    checkOutput("total_failed_pulses", fail_pulses, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
